// File: rtl/led_pattern_player.sv
// LED output stage: loadable OFF / ON / BLINK / 16-bit PATTERN behaviour stepped by the
// 1 ms tick, dimmed by a free-running 4-bit PWM. LED_RED and WRAP are registered.
module led_pattern_player (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MS_TICK,
  input  logic        LOAD,
  input  logic [1:0]  MODE,
  input  logic [9:0]  HALF_PERIOD_MS,
  input  logic [15:0] PATTERN,
  input  logic [3:0]  BRIGHTNESS,
  output logic        LED_RED,
  output logic        WRAP
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_PATTERN = 2'b11
  } mode_e;

  // LOAD is a one-cycle strobe with no back-pressure: every cycle it is high the
  // inputs are captured and the sequence restarts, so the last LOAD wins.
  mode_e       mode_q, mode_d;
  logic [9:0]  half_q, half_d;
  logic [15:0] pat_q, pat_d;
  logic [3:0]  bri_q, bri_d;
  logic [9:0]  ms_cnt_q, ms_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic [3:0]  pwm_cnt_q, pwm_cnt_d;
  logic        led_q, led_d;
  logic        wrap_q, wrap_d;

  logic [9:0]  last_cnt;
  logic        stepping;
  logic        step;
  logic        level;
  logic        pwm_lit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q    <= MODE_OFF;
      half_q    <= 10'd1;
      pat_q     <= 16'h0000;
      bri_q     <= 4'hF;
      ms_cnt_q  <= 10'd0;
      idx_q     <= 4'hF;
      phase_q   <= 1'b1;
      pwm_cnt_q <= 4'd0;
      led_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      half_q    <= half_d;
      pat_q     <= pat_d;
      bri_q     <= bri_d;
      ms_cnt_q  <= ms_cnt_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
      wrap_q    <= wrap_d;
    end
  end

  // A half-period of 0 behaves as 1, so the terminal count is 0 in both cases.
  always_comb begin
    last_cnt = (half_q == 10'd0) ? 10'd0 : half_q - 10'd1;
    stepping = (mode_q == MODE_BLINK) || (mode_q == MODE_PATTERN);
    step     = !LOAD && MS_TICK && stepping && (ms_cnt_q == last_cnt);
  end

  always_comb begin
    mode_d    = mode_q;
    half_d    = half_q;
    pat_d     = pat_q;
    bri_d     = bri_q;
    ms_cnt_d  = ms_cnt_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    wrap_d    = 1'b0;
    pwm_cnt_d = (pwm_cnt_q == 4'd14) ? 4'd0 : pwm_cnt_q + 4'd1;

    if (LOAD) begin
      mode_d   = mode_e'(MODE);
      half_d   = HALF_PERIOD_MS;
      pat_d    = PATTERN;
      bri_d    = BRIGHTNESS;
      ms_cnt_d = 10'd0;
      idx_d    = 4'hF;
      phase_d  = 1'b1;
    end else if (!stepping) begin
      ms_cnt_d = 10'd0;
    end else if (MS_TICK) begin
      ms_cnt_d = step ? 10'd0 : ms_cnt_q + 10'd1;
      if (step && mode_q == MODE_BLINK) begin
        phase_d = ~phase_q;
        wrap_d  = ~phase_q;
      end
      if (step && mode_q == MODE_PATTERN) begin
        idx_d  = idx_q - 4'd1;
        wrap_d = (idx_q == 4'd0);
      end
    end
  end

  always_comb begin
    level = 1'b0;
    case (mode_q)
      MODE_OFF:     level = 1'b0;
      MODE_ON:      level = 1'b1;
      MODE_BLINK:   level = phase_q;
      MODE_PATTERN: level = pat_q[idx_q];
      default:      level = 1'b0;
    endcase
    pwm_lit = (bri_q == 4'hF) || (pwm_cnt_q < bri_q);
    led_d   = level & pwm_lit;
  end

  assign LED_RED = led_q;
  assign WRAP    = wrap_q;

endmodule

// File: doc/led_pattern_player.md
# led_pattern_player

Downstream LED output stage driven by the board's 1 ms tick. It replaces a fixed divide-down blink with a loadable LED behaviour: off, on, square-wave blink with a programmable half-period, or a 16-bit repeating pattern. The LED level is dimmed by a 4-bit PWM. LED_RED goes straight to the pin.

## Interface
- None. All widths are fixed.
- CLK  in  1  system clock (50 MHz board clock); only clock, all logic on posedge.
- RST  in  1  reset; asynchronous, active-high.
- MS_TICK  in  1  one-CLK-wide strobe, once per millisecond, synchronous to CLK.
- LOAD  in  1  one-CLK strobe; captures MODE, HALF_PERIOD_MS, PATTERN, BRIGHTNESS and restarts the sequence.
- MODE  in  2  00 OFF, 01 ON, 10 BLINK, 11 PATTERN.
- HALF_PERIOD_MS  in  10  step length in ms; 0 treated as 1.
- PATTERN  in  16  pattern bits, played MSB first.
- BRIGHTNESS  in  4  PWM duty = BRIGHTNESS/15; 0 dark, 15 full on.
- LED_RED  out  1  registered LED drive.
- WRAP  out  1  one-CLK pulse at the end of each blink period or pattern pass.

## Operation
- Shadow registers mode_r, half_r, pat_r, bri_r load only on LOAD. Inputs are ignored at all other times.
- Step timer:
  - ms_cnt (10 bit) increments on MS_TICK.
  - When MS_TICK arrives and ms_cnt == max(half_r,1)-1, ms_cnt clears and a step occurs.
  - Steps happen only in BLINK and PATTERN. In OFF and ON, ms_cnt holds at 0.
- BLINK:
  - Level = phase. phase starts at 1 (lit) and toggles every step.
  - A 0->1 toggle pulses WRAP.
- PATTERN:
  - idx (4 bit) starts at 15. Level = pat_r[idx]; idx decrements every step.
  - The step from 0 to 15 wraps the index and pulses WRAP.
- OFF: level 0. ON: level 1.
- PWM:
  - pwm_cnt runs freely 0..14 and wraps to 0, advancing every CLK. It is never cleared by LOAD.
  - pwm_lit = (pwm_cnt < bri_r), or bri_r == 15.
- LED_RED <= level & pwm_lit, registered.
- LOAD action:
  - Captures all inputs.
  - ms_cnt <= 0, idx <= 15, phase <= 1, WRAP <= 0.
  - Legal in any mode and at any time, including mid-step, mid-pattern and back-to-back cycles. The last LOAD wins.
- LOAD and MS_TICK in the same cycle: LOAD wins and that tick is discarded.
- Changing the MODE, PATTERN etc. pins without LOAD has no effect.

## Timing
- Reset values:
  - mode_r = OFF, half_r = 1, pat_r = 0, bri_r = 15.
  - ms_cnt = 0, idx = 15, phase = 1, pwm_cnt = 0.
  - LED_RED = 0, WRAP = 0.
- Reset is asynchronous. Asserting RST mid-sequence forces the reset values immediately. The first MS_TICK after deassertion counts as tick 1.
- LOAD latency: LOAD sampled at edge n. LED_RED shows the new mode's level (gated by PWM) at edge n+1.
- Step latency: a step caused by the MS_TICK sampled at edge n updates phase/idx at edge n. LED_RED follows at edge n+1.
- WRAP is asserted for exactly the CLK after the wrapping edge. It is never asserted in OFF or ON.
- Blink period = 2*max(half_r,1) ms. Pattern pass = 16*max(half_r,1) ms.
- PWM period = 15 CLK (300 ns at 50 MHz), which is far above flicker.
- With bri_r = 15, LED_RED is a clean square wave, one CLK behind the level.

## Test plan
- Reset, then MS_TICK running: LED_RED = 0 and WRAP = 0 indefinitely. After RST pulse mid-BLINK, LED_RED = 0 on the next sample.
- LOAD MODE=10, HALF_PERIOD_MS=3, BRIGHTNESS=15:
  - LED_RED high for 3 ticks, low for 3 ticks, repeating.
  - One WRAP per 6 ticks, aligned with each low->high transition.
  - With HALF_PERIOD_MS=0, LED_RED toggles every tick.
- LOAD MODE=11, PATTERN=16'hA00F, HALF_PERIOD_MS=1, BRIGHTNESS=15:
  - LED_RED sequence per tick is 1,0,1,0,0,0,0,0,0,0,0,0,1,1,1,1, then repeats.
  - WRAP pulses once per 16 ticks.
- LOAD MODE=01, BRIGHTNESS=5:
  - LED_RED high exactly 5 of every 15 CLKs, in steady state.
  - BRIGHTNESS=0 gives constant 0. BRIGHTNESS=15 gives constant 1.
- LOAD asserted in the same cycle as MS_TICK, mid-pattern with idx=7:
  - idx resets to 15 and ms_cnt = 0.
  - The next step occurs only after a further max(half_r,1) ticks.
- Input pins changed without LOAD: LED_RED behaviour is unchanged. A subsequent LOAD applies the new values within 1 CLK.
